// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared 7-segment definitions for the display drivers on this board.
// Holds the special digit codes, the glyph constants (bit0 = a ... bit6 = g,
// active-high) and the code-to-glyph decoder shared by every encoder.
// ---------------------------------------------------------------------------
package seg_pkg;

    // Codes beyond 0-9 that the scoreboard logic uses.
    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_P     = 4'd11;

    // Glyphs, written g..a from left to right.
    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111101;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1101111;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0] GLYPH_P     = 7'b1110011;
    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;

    // Codes 12-15 are not meaningful digits and render as a dash so a bad
    // value is visible on the panel instead of silently disappearing.
    function automatic logic [6:0] code_to_seg(input logic [3:0] code);
        logic [6:0] glyph;
        case (code)
            4'd0:       glyph = GLYPH_0;
            4'd1:       glyph = GLYPH_1;
            4'd2:       glyph = GLYPH_2;
            4'd3:       glyph = GLYPH_3;
            4'd4:       glyph = GLYPH_4;
            4'd5:       glyph = GLYPH_5;
            4'd6:       glyph = GLYPH_6;
            4'd7:       glyph = GLYPH_7;
            4'd8:       glyph = GLYPH_8;
            4'd9:       glyph = GLYPH_9;
            CODE_BLANK: glyph = GLYPH_BLANK;
            CODE_P:     glyph = GLYPH_P;
            default:    glyph = GLYPH_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_mux_driver_scan_timer.sv
// ---------------------------------------------------------------------------
// seg_scan_timer
// Scan timebase for the multiplexed display: slot prescaler, digit index,
// dead-time flag, frame pulse and blink counter/phase.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   enable_i        0 clears and holds prescaler, index and blink counter
//   idx_o           digit currently being scanned
//   dead_o          1 while the prescaler is inside the slot's dead time
//   frame_o         registered one-cycle pulse per completed frame
//   blink_phase_o   1 during the "off" half of the blink period
// ---------------------------------------------------------------------------
module seg_scan_timer #(
    parameter int SCAN_DIV     = 1000,
    parameter int NUM_DIGITS   = 4,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    output logic [$clog2(NUM_DIGITS)-1:0] idx_o,
    output logic                          dead_o,
    output logic                          frame_o,
    output logic                          blink_phase_o
);

    localparam int PRESC_W = $clog2(SCAN_DIV + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] DEAD_END   = PRESC_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               frame_q, frame_d;
    logic               slot_end, frame_end;

    // The blink phase is deliberately not cleared by enable_i so a display
    // that is briefly switched off resumes in the same blink half.
    always_comb begin
        presc_d       = presc_q;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_d       = 1'b0;
        slot_end      = (presc_q == PRESC_LAST);
        frame_end     = slot_end && (idx_q == IDX_LAST);

        if (!enable_i) begin
            presc_d     = '0;
            idx_d       = '0;
            blink_cnt_d = '0;
        end else begin
            if (slot_end) begin
                presc_d = '0;
                idx_d   = frame_end ? '0 : idx_q + IDX_W'(1);
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end

            if (frame_end) begin
                frame_d = 1'b1;
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q       <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            frame_q       <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            frame_q       <= frame_d;
        end
    end

    assign idx_o         = idx_q;
    assign dead_o        = (presc_q < DEAD_END);
    assign frame_o       = frame_q;
    assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/seg_mux_driver.sv
// ---------------------------------------------------------------------------
// seg_mux_driver
// Time-multiplexed 7-segment driver for NUM_DIGITS BCD digits sharing one
// segment bus, with shadow-register load, anti-ghosting dead time,
// leading-zero blanking, per-digit blink and selectable output polarity.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   digits_i        digit codes, nibble k drives digit k (MSD is highest)
//   load_i          capture digits_i into the shadow register
//   enable_i        0 = dark display, scan held at digit 0
//   blank_lz_i      1 = blank leading zeros (digit 0 always shown)
//   blink_mask_i    1 = digit k blinks
//   seg_o           segments, bit0 = a ... bit6 = g
//   dig_sel_o       one-hot digit enable
//   frame_o         one-cycle pulse per completed scan frame
// ---------------------------------------------------------------------------
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEAD_CYCLES    = 2,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    load_i,
    input  logic                    enable_i,
    input  logic                    blank_lz_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   dig_sel_o,
    output logic                    frame_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [6:0]            SEG_INACTIVE = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_INACTIVE = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [6:0]                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0]      dig_sel_q, dig_sel_d;

    logic [IDX_W-1:0]      scan_idx;
    logic                  scan_dead;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;
    logic [3:0]            cur_code;
    logic                  cur_blank;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] sel_raw;

    seg_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .NUM_DIGITS   (NUM_DIGITS),
        .DEAD_CYCLES  (DEAD_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_scan_timer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .idx_o         (scan_idx),
        .dead_o        (scan_dead),
        .frame_o       (frame_o),
        .blink_phase_o (blink_phase)
    );

    // Loading is independent of enable_i so the value can be staged while dark.
    always_comb begin
        shadow_d = load_i ? digits_i : shadow_q;
    end

    // Walk from the most significant digit down; a digit is a leading zero
    // only if it and everything above it is zero. Digit 0 is never a
    // candidate so an all-zero value still shows "0".
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (shadow_q[k] == 4'd0);
            lz_mask[k] = zero_above && (k > 0);
        end
    end

    // Output stage works on the timer's current state, so the pins lag the
    // prescaler/index by one cycle. Polarity is folded in last.
    always_comb begin
        cur_code  = CODE_BLANK;
        cur_blank = 1'b0;
        sel_raw   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_code   = shadow_q[k];
                cur_blank  = (blink_mask_i[k] & blink_phase) | (blank_lz_i & lz_mask[k]);
                sel_raw[k] = 1'b1;
            end
        end

        seg_raw = cur_blank ? GLYPH_BLANK : code_to_seg(cur_code);

        if (!enable_i || scan_dead) begin
            seg_raw = GLYPH_BLANK;
            sel_raw = '0;
        end

        seg_d     = seg_raw ^ SEG_INACTIVE;
        dig_sel_d = sel_raw ^ DIG_INACTIVE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= {NUM_DIGITS{CODE_BLANK}};
            seg_q     <= SEG_INACTIVE;
            dig_sel_q <= DIG_INACTIVE;
        end else begin
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign seg_o     = seg_q;
    assign dig_sel_o = dig_sel_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_mux_driver
// Self-checking bench for seg_mux_driver (4 digits, 4-cycle slots, 1 dead
// cycle, 2-frame blink half-period, active-high outputs). A behavioural
// model derives the expected pins from the elapsed scan time; directed
// literal checks pin the model, then randomized traffic exercises it.
// ---------------------------------------------------------------------------
module tb_seg_mux_driver;

    localparam int ND    = 4;
    localparam int SDIV  = 4;
    localparam int DEAD  = 1;
    localparam int BLINK = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   digits;
    logic          load;
    logic          enable;
    logic          blank_lz;
    logic [3:0]    blink_mask;
    logic [6:0]    seg;
    logic [3:0]    dig_sel;
    logic          frame;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    seg_mux_driver #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SDIV),
        .DEAD_CYCLES    (DEAD),
        .BLINK_FRAMES   (BLINK),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .digits_i     (digits),
        .load_i       (load),
        .enable_i     (enable),
        .blank_lz_i   (blank_lz),
        .blink_mask_i (blink_mask),
        .seg_o        (seg),
        .dig_sel_o    (dig_sel),
        .frame_o      (frame)
    );

    always #5 clk = ~clk;

    // Independent glyph table, g..a.
    logic [6:0] glyph_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b0000000, 7'b1110011,
        7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
    };

    // Model state: m_p = enabled cycles since the scan last restarted.
    int         m_p = 0;
    bit         m_base = 1'b0;
    logic [3:0] m_shadow [4] = '{4'd10, 4'd10, 4'd10, 4'd10};
    logic [6:0] exp_seg = '0;
    logic [3:0] exp_sel = '0;
    logic       exp_frame = 1'b0;

    // Behavioural model: each clock edge the pins reflect where the scan
    // was before the edge (slot position, digit, frame count).
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_p       = 0;
                m_base    = 1'b0;
                for (int i = 0; i < ND; i++) m_shadow[i] = 4'd10;
                exp_seg   = '0;
                exp_sel   = '0;
                exp_frame = 1'b0;
            end else begin
                bit phase;
                phase = m_base ^ (((m_p / (SDIV * ND * BLINK)) % 2) == 1);
                if (enable) begin
                    int slot;
                    int dg;
                    bit zeros_above;
                    slot      = m_p % SDIV;
                    dg        = (m_p / SDIV) % ND;
                    exp_frame = ((m_p % (SDIV * ND)) == SDIV * ND - 1);
                    if (slot < DEAD) begin
                        exp_seg = '0;
                        exp_sel = '0;
                    end else begin
                        exp_sel = 4'(1 << dg);
                        zeros_above = 1'b1;
                        for (int j = dg; j < ND; j++)
                            if (m_shadow[j] != 4'd0) zeros_above = 1'b0;
                        if (blink_mask[dg] && phase)
                            exp_seg = '0;
                        else if (blank_lz && dg > 0 && zeros_above)
                            exp_seg = '0;
                        else
                            exp_seg = glyph_tab[m_shadow[dg]];
                    end
                    m_p++;
                end else begin
                    exp_seg   = '0;
                    exp_sel   = '0;
                    exp_frame = 1'b0;
                    m_base    = phase;
                    m_p       = 0;
                end
                if (load)
                    for (int i = 0; i < ND; i++) m_shadow[i] = digits[4*i +: 4];
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("model seg_o", 32'(seg), 32'(exp_seg));
        checkValue("model dig_sel_o", 32'(dig_sel), 32'(exp_sel));
        checkValue("model frame_o", 32'(frame), 32'(exp_frame));
    endtask

    // Compare process: DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) checkOutput();
        end
    end

    task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic en,
                                 input logic lz, input logic [3:0] mask);
        load       = ld;
        digits     = d;
        enable     = en;
        blank_lz   = lz;
        blink_mask = mask;
    endtask

    task automatic loadValue(input logic [15:0] d);
        load   = 1'b1;
        digits = d;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic waitSel(input logic [3:0] want);
        int n;
        n = 0;
        @(negedge clk);
        while (dig_sel !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) checkValue("waitSel timeout", 32'(dig_sel), 32'(want));
    endtask

    task automatic waitFrame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) checkValue("waitFrame timeout", 32'(frame), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000);

        // Reset state
        repeat (3) @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        checkValue("reset seg_o", 32'(seg), 32'd0);
        checkValue("reset dig_sel_o", 32'(dig_sel), 32'd0);
        checkValue("reset frame_o", 32'(frame), 32'd0);
        rst_n = 1'b1;

        // Idle without load: every digit blank but still scanned
        waitSel(4'b0001);
        checkValue("idle digit0 blank", 32'(seg), 32'd0);
        waitSel(4'b1000);
        checkValue("idle digit3 blank", 32'(seg), 32'd0);

        // Frame period is NUM_DIGITS * SCAN_DIV cycles
        waitFrame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame !== 1'b1 && n < 40);
        checkValue("frame period", 32'(n), 32'd16);

        // Scan order with dead time
        loadValue(16'h1234);
        waitSel(4'b0001);
        checkValue("scan d0=4", 32'(seg), 32'b1100110);
        waitSel(4'b0010);
        checkValue("scan d1=3", 32'(seg), 32'b1001111);
        waitSel(4'b0100);
        checkValue("scan d2=2", 32'(seg), 32'b1011011);
        waitSel(4'b1000);
        checkValue("scan d3=1", 32'(seg), 32'b0000110);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkValue("dead cycle sel", 32'(dig_sel), 32'd0);

        // Load mid-slot: old glyph for one more cycle, new one after that
        waitSel(4'b0100);
        load   = 1'b1;
        digits = 16'h1834;
        @(negedge clk);
        load = 1'b0;
        checkValue("mid-load old glyph", 32'(seg), 32'b1011011);
        @(negedge clk);
        checkValue("mid-load new glyph", 32'(seg), 32'b1111111);

        // enable_i low for three cycles, then restart at digit 0
        waitSel(4'b0010);
        enable = 1'b0;
        @(negedge clk);
        checkValue("disabled sel", 32'(dig_sel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        checkValue("re-enable dead sel", 32'(dig_sel), 32'd0);
        @(negedge clk);
        checkValue("re-enable digit0 sel", 32'(dig_sel), 32'b0001);
        checkValue("re-enable digit0 seg", 32'(seg), 32'b1100110);

        // Leading-zero blanking
        blank_lz = 1'b1;
        loadValue(16'h0070);
        waitSel(4'b0001);
        checkValue("lz d0=0", 32'(seg), 32'b0111111);
        waitSel(4'b0010);
        checkValue("lz d1=7", 32'(seg), 32'b0000111);
        waitSel(4'b0100);
        checkValue("lz d2 blank", 32'(seg), 32'd0);
        waitSel(4'b1000);
        checkValue("lz d3 blank", 32'(seg), 32'd0);
        loadValue(16'h0000);
        waitSel(4'b0010);
        checkValue("lz all-zero d1 blank", 32'(seg), 32'd0);
        waitSel(4'b0001);
        checkValue("lz all-zero d0 shows 0", 32'(seg), 32'b0111111);
        blank_lz = 1'b0;
        loadValue(16'h0070);
        waitSel(4'b1000);
        checkValue("no-lz d3=0", 32'(seg), 32'b0111111);

        // Blink and special codes, from a fresh reset so the phase is known
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'hB5AF, 1'b1, 1'b0, 4'b0001);
        @(negedge clk);
        load = 1'b0;
        waitSel(4'b0001);
        checkValue("code 15 dash", 32'(seg), 32'b1000000);
        waitSel(4'b0010);
        checkValue("code 10 blank", 32'(seg), 32'd0);
        waitSel(4'b0100);
        checkValue("code 5", 32'(seg), 32'b1101101);
        waitSel(4'b1000);
        checkValue("code 11 P", 32'(seg), 32'b1110011);
        waitFrame();
        waitFrame();
        waitSel(4'b0001);
        checkValue("blink off d0", 32'(seg), 32'd0);
        waitSel(4'b0100);
        checkValue("blink unmasked d2", 32'(seg), 32'b1101101);
        waitFrame();
        waitFrame();
        waitSel(4'b0001);
        checkValue("blink on again d0", 32'(seg), 32'b1000000);

        // Asynchronous reset mid-slot
        blink_mask = 4'b0000;
        loadValue(16'h8888);
        waitSel(4'b0010);
        #1 rst_n = 1'b0;
        #1;
        checkValue("async reset seg", 32'(seg), 32'd0);
        checkValue("async reset sel", 32'(dig_sel), 32'd0);
        checkValue("async reset frame", 32'(frame), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waitSel(4'b0001);
        checkValue("shadow blank after reset", 32'(seg), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] d;
            @(negedge clk);
            for (int i = 0; i < ND; i++)
                d[4*i +: 4] = ($urandom_range(0, 3) < 2) ? 4'd0 : 4'($urandom_range(0, 15));
            applyStimulus(($urandom_range(0, 7) == 0), d,
                          ($urandom_range(0, 63) != 0),
                          (($urandom_range(0, 99) == 0) ? ~blank_lz : blank_lz),
                          (($urandom_range(0, 199) == 0) ? 4'($urandom_range(0, 15)) : blink_mask));
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
Parametrised, time-multiplexed 7-segment driver for NUM_DIGITS BCD digits sharing one segment bus. Adds several features to the per-digit encoder:
- shadow-register load handshake
- scan timing with anti-ghosting dead time
- leading-zero blanking
- per-digit blink
- configurable output polarity

It sits between the scoreboard counter/BCD logic and the board pins.

Parameters:
- NUM_DIGITS, 4, number of digits; must be >= 2.
- SCAN_DIV, 1000, clk_i cycles per digit slot; must be > DEAD_CYCLES.
- DEAD_CYCLES, 2, cycles at the start of each slot with all digits off.
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be >= 1.
- SEG_ACTIVE_LOW, 0, 1 inverts seg_o.
- DIG_ACTIVE_LOW, 0, 1 inverts dig_sel_o.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- digits_i  in  4*NUM_DIGITS  digit codes; nibble k drives digit k; digit NUM_DIGITS-1 is the most significant.
- load_i  in  1  capture digits_i into the shadow register.
- enable_i  in  1  0 = display dark and scan held.
- blank_lz_i  in  1  1 = blank leading zeros.
- blink_mask_i  in  NUM_DIGITS  1 = digit k blinks.
- seg_o  out  7  segments; bit0=a … bit6=g.
- dig_sel_o  out  NUM_DIGITS  one-hot digit enable.
- frame_o  out  1  one-cycle pulse per completed scan frame.

Behaviour:
Clock and reset (already decided): one clock, clk_i; reset rst_ni is asynchronous and active-low.

Reset values:
- shadow register: every nibble = 10 (blank).
- prescaler = 0, digit index = 0, blink counter = 0, blink phase = 0.
- frame_o = 0.
- seg_o = inactive level (all 0 if SEG_ACTIVE_LOW=0, else all 1).
- dig_sel_o = all inactive.

Code map:
- 0-9: decimal glyphs, i.e. 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- 10: blank (0000000).
- 11: 'P' (1110011).
- 12-15: dash (1000000).

Load:
- load_i high at edge N → shadow updated at edge N.
- The new value can appear on seg_o from edge N+1.
- load_i held high reloads every cycle. No acknowledge.

Scan:
- Prescaler counts 0..SCAN_DIV-1 and wraps.
- On wrap, digit index advances 0→1→…→NUM_DIGITS-1→0.
- frame_o pulses for exactly one cycle in the cycle the index wraps NUM_DIGITS-1→0.

Registered outputs, one cycle after the prescaler/index they derive from:
- While prescaler < DEAD_CYCLES: dig_sel_o all inactive, seg_o inactive.
- Otherwise: dig_sel_o one-hot at the index, seg_o = glyph of the effective code.

Effective code, priority high to low:
1. enable_i=0 → dark.
2. Blink: blink_mask_i[k] and blink phase=1 → blank.
3. Leading-zero blanking: blank_lz_i=1, digit k>0, and every shadow nibble from NUM_DIGITS-1 down to k equals 0 → blank. Digit 0 is never LZ-blanked, so all zeros shows "0".
4. Otherwise the shadow nibble.

Blink:
- Blink counter counts frame_o pulses.
- At BLINK_FRAMES pulses it clears and blink phase toggles.

enable_i=0:
- Prescaler, index and blink counter are cleared and held at 0.
- frame_o = 0 and outputs are inactive.
- Shadow load still works.
- On re-enable, scanning restarts at digit 0 with a dead-time window.

Other boundary conditions:
- Reset mid-slot forces all outputs inactive immediately (asynchronous) and restarts at digit 0.
- Polarity inversion is applied as the last stage of the output registers.

Decomposition:
- Package seg_pkg:
  - CODE_BLANK=10, CODE_P=11.
  - 7-bit glyph constants.
  - function code_to_seg (4-bit code → 7-bit glyph).
  - shared with the existing two-digit encoder.
- Sub-module seg_scan_timer:
  - contains the prescaler, digit index, dead-time flag, frame pulse and blink counter/phase.
  - parameters SCAN_DIV, NUM_DIGITS, DEAD_CYCLES, BLINK_FRAMES.
- Top level contains the shadow register, LZ/blink/priority logic and output registers.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2, active-high outputs.
- Reset/idle: hold rst_ni=0 → seg_o=0000000, dig_sel_o=0000, frame_o=0. Release without load → every digit shows blank. frame_o pulses every 16 cycles.
- Scan order and dead time: load 0x1234, enable_i=1 → per slot, 1 cycle dark then 3 cycles of digit0=4 (1100110, sel 0001), then digit1=3, digit2=2, digit3=1 (sel 1000).
- Leading-zero blanking: load 0x0070, blank_lz_i=1 → digits 3 and 2 blank, digit1=7, digit0=0 (0111111). Load 0x0000 → only digit0 lit, showing 0. With blank_lz_i=0, load 0x0070 → all four digits lit.
- Blink and codes: load 0xB5AF, blink_mask_i=0001 → digit3 'P', digit2 '5', digit1 blank, digit0 dash. Digit0 dark after 2 frames, lit again after 4 frames.
- Mid-operation events: load mid-slot → new glyph on the next cycle. enable_i=0 for 3 cycles → outputs dark, then restart at digit0 with a dead cycle. rst_ni pulsed low mid-slot → outputs inactive in the same cycle, shadow reads back as blank.
